vga_scan_driver: RTL



---
 rtl/vga_scan_driver.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/vga_scan_driver.sv
// vga_scan_driver: raster timing generator and registered pixel output stage.
//
// Produces scan coordinates (vga_xpos/vga_ypos) for the game controller, samples
// the 1-bit colours it returns, blanks them outside the visible window and drives
// registered RGB, HSYNC, VSYNC and DE. Also exports a pixel-rate enable and a
// one-cycle frame-start strobe with an 8-bit frame counter.
//
// Ports:
//   clk                         system clock
//   rst                         asynchronous active-low reset
//   vga_xpos [10:0]             horizontal scan count, 0..H_TOTAL-1
//   vga_ypos [9:0]              vertical scan count, 0..V_TOTAL-1
//   vga_red/green/blue          colour for the current coordinate (combinational)
//   vga_r_o/g_o/b_o             registered, blanked colour pins
//   vga_hs, vga_vs              registered sync pins, polarity set by SYNC_POL
//   vga_de                      registered display enable, aligned with RGB
//   pix_en                      one-clk pulse per pixel period
//   frame_start                 one-clk pulse on the pixel where the scan wraps to (0,0)
//   frame_cnt [7:0]             frame counter, wraps 255->0
module vga_scan_driver #(
   parameter int unsigned CLK_DIV  = 2,
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned SYNC_POL = 0
) (
   input  logic        clk,
   input  logic        rst,
   output logic [10:0] vga_xpos,
   output logic [9:0]  vga_ypos,
   input  logic        vga_red,
   input  logic        vga_green,
   input  logic        vga_blue,
   output logic        vga_r_o,
   output logic        vga_g_o,
   output logic        vga_b_o,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_de,
   output logic        pix_en,
   output logic        frame_start,
   output logic [7:0]  frame_cnt
);

   localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned DivW    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

   localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);
   localparam logic [10:0] HLast    = 11'(H_TOTAL - 1);
   localparam logic [10:0] HActEnd  = 11'(H_ACTIVE);
   localparam logic [10:0] HSyncBeg = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HSyncEnd = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [9:0]  VLast    = 10'(V_TOTAL - 1);
   localparam logic [9:0]  VActEnd  = 10'(V_ACTIVE);
   localparam logic [9:0]  VSyncBeg = 10'(V_ACTIVE + V_FP);
   localparam logic [9:0]  VSyncEnd = 10'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        PolHigh  = (SYNC_POL != 0);

   logic [DivW-1:0] div_cnt_q, div_cnt_d;
   logic            pix_en_q, pix_en_d;
   logic [10:0]     h_cnt_q, h_cnt_d;
   logic [9:0]      v_cnt_q, v_cnt_d;
   logic [7:0]      frame_cnt_q, frame_cnt_d;
   logic            de_q, r_q, g_q, b_q, hs_q, vs_q;

   logic h_wrap, v_wrap, frame_wrap;
   logic active, hs_act, vs_act;

   always_comb begin
      div_cnt_d = (div_cnt_q == DivLast) ? '0 : div_cnt_q + DivW'(1);
      // pix_en is registered so it stays low during reset even when CLK_DIV=1,
      // yet is high exactly in the cycles where div_cnt_q == CLK_DIV-1.
      pix_en_d  = (div_cnt_d == DivLast);

      h_wrap     = (h_cnt_q == HLast);
      v_wrap     = (v_cnt_q == VLast);
      frame_wrap = pix_en_q & h_wrap & v_wrap;

      h_cnt_d = h_cnt_q;
      v_cnt_d = v_cnt_q;
      if (pix_en_q) begin
         h_cnt_d = h_wrap ? '0 : h_cnt_q + 11'd1;
         if (h_wrap) begin
            v_cnt_d = v_wrap ? '0 : v_cnt_q + 10'd1;
         end
      end
      frame_cnt_d = frame_wrap ? frame_cnt_q + 8'd1 : frame_cnt_q;

      active = (h_cnt_q < HActEnd) && (v_cnt_q < VActEnd);
      hs_act = (h_cnt_q >= HSyncBeg) && (h_cnt_q < HSyncEnd);
      vs_act = (v_cnt_q >= VSyncBeg) && (v_cnt_q < VSyncEnd);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_cnt_q   <= '0;
         pix_en_q    <= 1'b0;
         h_cnt_q     <= '0;
         v_cnt_q     <= '0;
         frame_cnt_q <= '0;
      end else begin
         div_cnt_q   <= div_cnt_d;
         pix_en_q    <= pix_en_d;
         h_cnt_q     <= h_cnt_d;
         v_cnt_q     <= v_cnt_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   // Output stage: one pixel period behind the coordinate it describes.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         de_q <= 1'b0;
         r_q  <= 1'b0;
         g_q  <= 1'b0;
         b_q  <= 1'b0;
         hs_q <= ~PolHigh;
         vs_q <= ~PolHigh;
      end else if (pix_en_q) begin
         de_q <= active;
         r_q  <= vga_red & active;
         g_q  <= vga_green & active;
         b_q  <= vga_blue & active;
         hs_q <= ~(hs_act ^ PolHigh);
         vs_q <= ~(vs_act ^ PolHigh);
      end
   end

   assign vga_xpos    = h_cnt_q;
   assign vga_ypos    = v_cnt_q;
   assign pix_en      = pix_en_q;
   assign frame_start = frame_wrap;
   assign frame_cnt   = frame_cnt_q;
   assign vga_de      = de_q;
   assign vga_r_o     = r_q;
   assign vga_g_o     = g_q;
   assign vga_b_o     = b_q;
   assign vga_hs      = hs_q;
   assign vga_vs      = vs_q;

endmodule
